mul_div_unit: RTL

Multicycle signed 32-bit multiply/divide unit that feeds the 64-bit Z (HI/LO) result register of the datapath. It accepts operands on a start pulse and iterates one radix-2 step per clock. It then presents a 64-bit result together with a one-cycle `z_enable` strobe, which drives the enable input of the downstream 64-bit register directly. Multiply uses Booth recoding; divide uses restoring division on magnitudes followed by a sign fix.

---
 rtl/mul_div_pkg.sv | 25 ++
 rtl/add_sub_33.sv | 18 +
 rtl/mul_div_unit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mul_div_pkg.sv
// rtl/mul_div_pkg.sv - shared types and constants for the multiply/divide unit
// Provides: state_e FSM encoding, OP_MUL/OP_DIV opcodes, DATA_WIDTH_DEF,
//           cnt_width() and CNT_W for the iteration counter.
package mul_div_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } state_e;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Counter must hold the value DATA_WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_width(DATA_WIDTH_DEF);

endpackage

// File: rtl/add_sub_33.sv
// rtl/add_sub_33.sv - combinational adder/subtractor shared by Booth and trial-subtract steps
// Ports:
//   x_i   in  WIDTH  left operand
//   y_i   in  WIDTH  right operand
//   sub_i in  1      1 = x_i - y_i, 0 = x_i + y_i
//   sum_o out WIDTH  result (wraps modulo 2^WIDTH)
module add_sub_33 #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o
);

  assign sum_o = sub_i ? (x_i - y_i) : (x_i + y_i);

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multicycle signed multiply (Booth) / divide (restoring) unit
// Ports:
//   clk         in  1       rising-edge clock
//   clear       in  1       synchronous active-high reset
//   start       in  1       request, sampled in IDLE only
//   op          in  1       0 = multiply, 1 = divide
//   a, b        in  W       operands (two's complement)
//   busy        out 1       high outside IDLE
//   done        out 1       one-cycle pulse, result valid
//   z_enable    out 1       same as done, drives Z register enable
//   div_by_zero out 1       valid with done, held until next accepted start
//   result      out 2W      mul: product; div: {remainder, quotient}
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic                    start,
  input  logic                    op,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic                    busy,
  output logic                    done,
  output logic                    z_enable,
  output logic                    div_by_zero,
  output logic [2*DATA_WIDTH-1:0] result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = cnt_width(W);

  state_e          state_q;
  logic            op_q;
  logic [W-1:0]    a_q;       // original dividend, for signs and div-by-zero remainder
  logic            b_neg_q;
  logic [W-1:0]    m_q;       // mul: multiplicand a; div: |b|
  logic [W-1:0]    q_q;       // mul: multiplier b; div: |a| shifting into quotient
  logic            qm1_q;     // Booth q_-1
  logic [W:0]      acc_q;     // extra bit keeps |-2^31| and Booth -(-2^31) exact
  logic [CW-1:0]   cnt_q;
  logic            dz_q;
  logic            busy_q;
  logic            done_q;
  logic            div_by_zero_q;
  logic [2*W-1:0]  result_q;

  logic [W:0]      acc_d;
  logic [W-1:0]    q_d;
  logic            qm1_d;
  logic [W:0]      shifted_r;
  logic [W:0]      add_x;
  logic [W:0]      add_y;
  logic            add_sub;
  logic [W:0]      add_s;
  logic [W:0]      booth_sel;
  logic [W-1:0]    a_mag;
  logic [W-1:0]    b_mag;
  logic [W-1:0]    quo_fix;
  logic [W-1:0]    rem_fix;
  logic [2*W-1:0]  fix_result;

  assign a_mag = a[W-1] ? (~a + 1'b1) : a;
  assign b_mag = b[W-1] ? (~b + 1'b1) : b;

  // Divide shifts the next dividend bit into the partial remainder.
  assign shifted_r = {acc_q[W-1:0], q_q[W-1]};
  assign add_x     = (op_q == OP_DIV) ? shifted_r : acc_q;
  assign add_y     = (op_q == OP_DIV) ? {1'b0, m_q} : {m_q[W-1], m_q};
  // Booth pair {Q0, q_-1} = 10 subtracts M, 01 adds M.
  assign add_sub   = (op_q == OP_DIV) | (q_q[0] & ~qm1_q);

  add_sub_33 #(
    .WIDTH (W + 1)
  ) u_add_sub (
    .x_i   (add_x),
    .y_i   (add_y),
    .sub_i (add_sub),
    .sum_o (add_s)
  );

  always_comb begin
    acc_d     = acc_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    booth_sel = acc_q;
    if (op_q == OP_DIV) begin
      if (!add_s[W]) begin
        acc_d = add_s;
        q_d   = {q_q[W-2:0], 1'b1};
      end else begin
        acc_d = shifted_r;
        q_d   = {q_q[W-2:0], 1'b0};
      end
    end else begin
      booth_sel = (q_q[0] ^ qm1_q) ? add_s : acc_q;
      acc_d     = {booth_sel[W], booth_sel[W:1]};
      q_d       = {booth_sel[0], q_q[W-1:1]};
      qm1_d     = q_q[0];
    end
  end

  always_comb begin
    quo_fix = (a_q[W-1] ^ b_neg_q) ? (~q_q + 1'b1) : q_q;
    rem_fix = a_q[W-1] ? (~acc_q[W-1:0] + 1'b1) : acc_q[W-1:0];
    if (op_q == OP_MUL) begin
      fix_result = {acc_q[W-1:0], q_q};
    end else if (dz_q) begin
      fix_result = {a_q, {W{1'b1}}};
    end else begin
      fix_result = {rem_fix, quo_fix};
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_MUL;
      a_q           <= '0;
      b_neg_q       <= 1'b0;
      m_q           <= '0;
      q_q           <= '0;
      qm1_q         <= 1'b0;
      acc_q         <= '0;
      cnt_q         <= '0;
      dz_q          <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
      result_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q          <= op;
            a_q           <= a;
            b_neg_q       <= b[W-1];
            qm1_q         <= 1'b0;
            acc_q         <= '0;
            cnt_q         <= '0;
            div_by_zero_q <= 1'b0;
            busy_q        <= 1'b1;
            if (op == OP_DIV) begin
              m_q     <= b_mag;
              q_q     <= a_mag;
              dz_q    <= (b == '0);
              state_q <= (b == '0) ? ST_FIX : ST_RUN;
            end else begin
              m_q     <= a;
              q_q     <= b;
              dz_q    <= 1'b0;
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          acc_q <= acc_d;
          q_q   <= q_d;
          qm1_q <= qm1_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) begin
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          result_q      <= fix_result;
          div_by_zero_q <= dz_q;
          done_q        <= 1'b1;
          state_q       <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign z_enable    = done_q;
  assign div_by_zero = div_by_zero_q;
  assign result      = result_q;

endmodule
